// File: rtl/vga_timing_pkg.sv
// Shared constants, region type and decode helper for the VGA raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  typedef enum logic [1:0] {
    ACTIVE,
    FP,
    SYNC,
    BP
  } region_e;

  function automatic region_e region_of(
    input int c,
    input int a,
    input int fp,
    input int s
  );
    region_e r;
    if (c < a)               r = ACTIVE;
    else if (c < a + fp)     r = FP;
    else if (c < a + fp + s) r = SYNC;
    else                     r = BP;
    return r;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter, wrap strobe and registered region decode.
// The region register tracks the next count so it lines up with cnt_o.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FP_LEN     = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BP_LEN     = 48,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output region_e       region_o
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  region_e       region_q, region_d;

  assign wrap_o = adv_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (wrap_o) cnt_d = '0;
    else if (adv_i)  cnt_d = cnt_q + CW'(1);
    region_d = region_of(int'(cnt_d), ACTIVE_LEN, FP_LEN, SYNC_LEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      region_q <= ACTIVE;
    end else begin
      cnt_q    <= cnt_d;
      region_q <= region_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign region_o = region_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel prescaler and colour gating.
// Define VGA_TEST_PATTERN_EN to replace iColor with an 8-bar test pattern.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iEnable,
  input  logic [2:0]    iColor,
  output logic          oHsync,
  output logic          oVsync,
  output logic          oRed,
  output logic          oGreen,
  output logic          oBlue,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oActive,
  output logic          oPixelTick,
  output logic          oFrameStart
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic POL = (SYNC_POL != 0);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;
  region_e       h_reg, v_reg;
  logic [2:0]    pix;
  logic          act;

  assign tick  = iEnable && (pre_q == PRE_LAST);
  assign pre_d = (!iEnable || tick) ? '0 : pre_q + PW'(1);

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP),
    .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .CW(CW)
  ) u_h (
    .clk(Clock), .rst_n(Reset),
    .clr_i(!iEnable), .adv_i(tick),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .region_o(h_reg)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP),
    .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .CW(CW)
  ) u_v (
    .clk(Clock), .rst_n(Reset),
    .clr_i(!iEnable), .adv_i(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .region_o(v_reg)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  assign pix = 3'(int'(h_cnt) / BAR);
`else
  assign pix = iColor;
`endif

  assign act = (h_reg == ACTIVE) && (v_reg == ACTIVE);

  logic       hs_q, vs_q, act_q, pt_q, fs_q;
  logic [2:0] rgb_q;
  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pre_q <= '0;
      hs_q  <= ~POL;
      vs_q  <= ~POL;
      rgb_q <= '0;
      act_q <= 1'b0;
      pt_q  <= 1'b0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (!iEnable) begin
      pre_q <= '0;
      hs_q  <= ~POL;
      vs_q  <= ~POL;
      rgb_q <= '0;
      act_q <= 1'b0;
      pt_q  <= 1'b0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      pre_q <= pre_d;
      hs_q  <= (h_reg == SYNC) ? POL : ~POL;
      vs_q  <= (v_reg == SYNC) ? POL : ~POL;
      rgb_q <= act ? pix : 3'b000;
      act_q <= act;
      pt_q  <= tick;
      fs_q  <= tick && (h_cnt == '0) && (v_cnt == '0);
      x_q   <= h_cnt;
      y_q   <= v_cnt;
    end
  end

  assign oHsync      = hs_q;
  assign oVsync      = vs_q;
  assign {oRed, oGreen, oBlue} = rgb_q;
  assign oActive     = act_q;
  assign oPixelTick  = pt_q;
  assign oFrameStart = fs_q;
  assign oX          = x_q;
  assign oY          = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x7 raster with CLK_DIV=2.
// Expected values come from the clock count since the raster (re)started.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iEnable = 1'b1;
  logic [2:0] iColor = 3'b000;
  logic       oHsync, oVsync, oRed, oGreen, oBlue;
  logic [9:0] oX, oY;
  logic       oActive, oPixelTick, oFrameStart;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(2), .SYNC_POL(0), .CW(10)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
    .iColor(iColor), .oHsync(oHsync), .oVsync(oVsync),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oX(oX), .oY(oY), .oActive(oActive),
    .oPixelTick(oPixelTick), .oFrameStart(oFrameStart)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".hs"}, 16'(oHsync), 16'd1);
    chk({tag, ".vs"}, 16'(oVsync), 16'd1);
    chk({tag, ".rgb"}, 16'({oRed, oGreen, oBlue}), 16'd0);
    chk({tag, ".act"}, 16'(oActive), 16'd0);
    chk({tag, ".pt"}, 16'(oPixelTick), 16'd0);
    chk({tag, ".fs"}, 16'(oFrameStart), 16'd0);
    chk({tag, ".x"}, 16'(oX), 16'd0);
    chk({tag, ".y"}, 16'(oY), 16'd0);
  endtask

  // n = index of the clock edge since restart (1 = first live edge)
  task automatic run(input string tag, input int cnt);
    int p, x, y;
    logic [2:0] c;
    logic a, pt;
    for (int n = 1; n <= cnt; n++) begin
      @(negedge Clock);
      c = 3'($urandom);
      iColor = c;
      @(posedge Clock);
      #1;
      p  = ((n - 1) / 2) % (HT * VT);
      x  = p % HT;
      y  = p / HT;
      a  = (x < HA) && (y < VA);
      pt = (n % 2 == 0);
      chk({tag, ".x"}, 16'(oX), 16'(x));
      chk({tag, ".y"}, 16'(oY), 16'(y));
      chk({tag, ".hs"}, 16'(oHsync), 16'(!(x == 10 || x == 11)));
      chk({tag, ".vs"}, 16'(oVsync), 16'(y != 5));
      chk({tag, ".act"}, 16'(oActive), 16'(a));
      chk({tag, ".rgb"}, 16'({oRed, oGreen, oBlue}),
          16'(a ? c : 3'b000));
      chk({tag, ".pt"}, 16'(oPixelTick), 16'(pt));
      chk({tag, ".fs"}, 16'(oFrameStart), 16'(pt && p == 0));
    end
  endtask

  initial begin
    iColor = 3'b101;
    repeat (2) @(posedge Clock);
    #1;
    chk_idle("reset");
    #1 Reset = 1'b1;

    // Full frame plus the first pixels of the next one.
    run("frame", 2 * HT * VT + 4);

    // Asynchronous reset mid-line: outputs drop with no clock edge.
    #1 Reset = 1'b0;
    #1 chk_idle("async_rst");
    #1 Reset = 1'b1;
    run("after_rst", 70);

    // Enable dropped on line 2 for 10 clocks.
    #1 iEnable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clock);
      #1;
      chk_idle("disabled");
    end
    #1 iEnable = 1'b1;
    run("after_en", 40);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync FSM.
- Generates Hsync/Vsync, pixel coordinates, active-video flag and a frame-start strobe from a system clock with an internal pixel-rate prescaler.
- Gates a 3-bit RGB colour input onto the DAC pins during active video.
- Sits between the board VGA connector and any pixel source (framebuffer, sprite logic).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1); 2 gives a 25 MHz pixel rate from 50 MHz
- SYNC_POL, 0, sync level while asserted (0 = active-low)
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- iEnable  in  1  run enable; low parks the raster at (0,0)
- iColor  in  3  {R,G,B} for the current pixel, sampled every clock
- oHsync  out  1  horizontal sync
- oVsync  out  1  vertical sync
- oRed, oGreen, oBlue  out  1 each  gated colour outputs
- oX  out  CW  current horizontal count
- oY  out  CW  current vertical count
- oActive  out  1  high while in the visible region
- oPixelTick  out  1  one-clock pulse per pixel period
- oFrameStart  out  1  one-clock pulse at the start of pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset (Reset=0, asynchronous):
  - prescaler, hcnt and vcnt cleared to 0.
  - oHsync and oVsync = ~SYNC_POL.
  - colours, oActive, oPixelTick, oFrameStart = 0; oX = oY = 0.
  - Release is synchronous to Clock.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps; tick = (prescaler == CLK_DIV-1).
  - CLK_DIV=1 gives tick every clock.
- Horizontal counter:
  - Advances only on tick; wraps H_TOTAL-1 -> 0.
  - Regions: active 0..H_ACTIVE-1, FP, SYNC, BP, in that order.
- Vertical counter:
  - Increments on a tick where hcnt == H_TOTAL-1; wraps V_TOTAL-1 -> 0.
  - Regions in the same order as horizontal.
- Output decode (all outputs registered; one clock latency from the counters):
  - hsync asserted (= SYNC_POL) iff hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync likewise on vcnt.
  - oActive = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - oX = hcnt, oY = vcnt.
  - Colour = iColor when active, else 3'b000. Blanking is forced during porches and sync.
  - oPixelTick = registered tick.
  - oFrameStart = registered (tick && hcnt==0 && vcnt==0).
- iEnable low:
  - Synchronously clears the prescaler and both counters, and holds them at 0.
  - Syncs deasserted, colours 0, oActive 0, ticks 0.
  - First tick after iEnable rises produces oFrameStart.
- Mid-frame deassert of iEnable or Reset aborts the frame; no partial-line completion.
- Counter wrap and line wrap occur on the same tick at the end of the frame; the next frame then begins with hcnt = vcnt = 0.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - iColor is ignored.
  - During active video the colour equals an internal 8-bar pattern: colour = hcnt / (H_ACTIVE/8), truncated to 3 bits.
  - Bar 0 = black, bar 7 = white.
- Undefined: the pattern logic is absent and colour comes from iColor.
- Timing outputs are identical in both cases.

Decomposition:
- Package vga_timing_pkg holds:
  - Default 640x480@60 constants.
  - Region-boundary helper constants (H_TOTAL, V_TOTAL, sync start and end).
  - Region enum: ACTIVE, FP, SYNC, BP.
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). It provides:
  - A parametrised wrapping up-counter with advance input.
  - A wrap strobe.
  - Registered region decode, including sync.

Test Plan:
- Defaults, CLK_DIV=2, iEnable=1 -> oHsync low for exactly 192 clocks every 1600 clocks; first low edge 1312 clocks after the line start.
- Defaults, full frame -> oVsync low for 2 lines (3200 clocks) every 525 lines (840000 clocks); oFrameStart pulses once per 840000 clocks.
- iColor=3'b101 held -> {R,G,B}=101 only while oActive; 0 during porches and sync; oActive high for 640 ticks per line on lines 0..479.
- Override H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, CLK_DIV=1 -> oX sequence 0..13 wraps, oY increments at oX=13, frame = 98 clocks.
- Reset pulled low mid-line (hcnt=300) -> outputs go to reset values immediately without a clock edge; after release the raster restarts at (0,0) with oFrameStart.
- iEnable dropped for 10 clocks at vcnt=200 -> counters hold 0, syncs inactive; oFrameStart on the first tick after re-enable.
- With VGA_TEST_PATTERN_EN -> pixel x=0 gives 000, x=80 gives 001, x=639 gives 111.
